// File: rtl/lshifter_seq.sv
// Sequential left shifter / normalizer: one power-of-two stage per clock, largest stage first,
// with valid/ready handshakes on input and output.
module lshifter_seq #(
    parameter int n = 8,
    parameter int s = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in,
    input  logic [s-1:0] sel,
    input  logic         norm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out,
    output logic [s-1:0] shamt,
    output logic         overflow,
    output logic         zero
);

    localparam int K_W = (s > 1) ? $clog2(s) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [n-1:0]   data_q, data_d;
    logic [s-1:0]   amt_q, amt_d;
    logic           ovf_q, ovf_d;
    logic           mode_q, mode_d;
    logic [s-1:0]   sel_q, sel_d;
    logic [K_W-1:0] k_q, k_d;

    logic [s-1:0]   step;
    logic [n-1:0]   hi_mask;
    logic           top_nz;
    logic           do_shift;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        amt_d   = amt_q;
        ovf_d   = ovf_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        k_d     = k_q;

        // Stage k shifts by 2**k; hi_mask covers the 2**k MSBs that would leave the word.
        step       = '0;
        step[k_q]  = 1'b1;
        hi_mask    = ~({n{1'b1}} >> step);
        top_nz     = |(data_q & hi_mask);
        do_shift   = mode_q ? ~top_nz : sel_q[k_q];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in;
                    sel_d   = sel;
                    mode_d  = norm;
                    amt_d   = '0;
                    ovf_d   = 1'b0;
                    k_d     = K_W'(s - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (do_shift) begin
                    data_d     = data_q << step;
                    amt_d[k_q] = 1'b1;
                    ovf_d      = ovf_q | top_nz;
                end
                if (k_q == '0) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q - K_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            ovf_q   <= 1'b0;
            mode_q  <= 1'b0;
            sel_q   <= '0;
            k_q     <= K_W'(s - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            ovf_q   <= ovf_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            k_q     <= k_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = data_q;
    assign shamt     = amt_q;
    assign overflow  = ovf_q;
    // zero is only meaningful with a result on the output
    assign zero      = out_valid && (data_q == '0);

endmodule

// File: tb/tb_lshifter_seq.sv
// Scoreboard bench for lshifter_seq: stimulus pushes hand-computed results, a monitor pops
// and compares them whenever a result is handed off.
module tb_lshifter_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in;
    logic [2:0] sel;
    logic       norm;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [2:0] shamt;
    logic       overflow;
    logic       zero;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] shamt;
        logic       ovf;
        logic       zero;
    } exp_t;

    exp_t sb[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    lshifter_seq #(.n(8), .s(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .sel       (sel),
        .norm      (norm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .shamt     (shamt),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(out), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out",      32'(out),      32'(e.data));
                check("shamt",    32'(shamt),    32'(e.shamt));
                check("overflow", 32'(overflow), 32'(e.ovf));
                check("zero",     32'(zero),     32'(e.zero));
            end
        end
    end

    // Waits for in_ready, then presents one operand for exactly the accepting edge.
    task automatic send(input logic [7:0] d, input logic [2:0] sh, input logic nm,
                        input logic push, input exp_t e);
        int unsigned t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            if (push) sb.push_back(e);
            in = d; sel = sh; norm = nm; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in = 8'hFF; sel = 3'd7; norm = ~nm;
        end
    endtask

    task automatic check_latency(input string name);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            check(name, 32'(out_valid), (i == 3) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic drain();
        int unsigned t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in = '0; sel = '0; norm = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out",       32'(out),       32'd0);
        check("rst_shamt",     32'(shamt),     32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_zero",      32'(zero),      32'd0);

        // Explicit shifts, overflow cases, sel=0 pass-through and shift-out-to-zero.
        send(8'h13, 3'd3, 1'b0, 1'b1, '{8'h98, 3'd3, 1'b0, 1'b0});
        check_latency("latency_explicit");
        send(8'hA1, 3'd2, 1'b0, 1'b1, '{8'h84, 3'd2, 1'b1, 1'b0});
        send(8'h3F, 3'd2, 1'b0, 1'b1, '{8'hFC, 3'd2, 1'b0, 1'b0});
        send(8'h5A, 3'd0, 1'b0, 1'b1, '{8'h5A, 3'd0, 1'b0, 1'b0});
        send(8'h81, 3'd7, 1'b0, 1'b1, '{8'h80, 3'd7, 1'b1, 1'b0});
        send(8'hF0, 3'd4, 1'b0, 1'b1, '{8'h00, 3'd4, 1'b1, 1'b1});

        // Normalize.
        send(8'h05, 3'd0, 1'b1, 1'b1, '{8'hA0, 3'd5, 1'b0, 1'b0});
        send(8'h80, 3'd5, 1'b1, 1'b1, '{8'h80, 3'd0, 1'b0, 1'b0});
        send(8'h00, 3'd2, 1'b1, 1'b1, '{8'h00, 3'd7, 1'b0, 1'b1});
        send(8'h3C, 3'd7, 1'b1, 1'b1, '{8'hF0, 3'd2, 1'b0, 1'b0});
        drain();

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send(8'h13, 3'd3, 1'b0, 1'b1, '{8'h98, 3'd3, 1'b0, 1'b0});
        check_latency("latency_bp");
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in = 8'h55; sel = 3'd1; norm = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_out",       32'(out),       32'h98);
            check("bp_shamt",     32'(shamt),     32'd3);
            check("bp_flags",     {30'd0, overflow, zero}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready",  32'(in_ready),  32'd1);

        // Reset during SHIFT abandons the operand.
        send(8'h13, 3'd3, 1'b0, 1'b0, '{8'h00, 3'd0, 1'b0, 1'b0});
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out",       32'(out),       32'd0);
        send(8'h01, 3'd0, 1'b1, 1'b1, '{8'h80, 3'd7, 1'b0, 1'b0});
        check_latency("latency_after_reset");
        drain();

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lshifter_seq.md
Name: lshifter_seq

Overview:
- Sequential left shifter / normalizer for the FPU datapath. It is the left-shift counterpart of the staged right shifter used for operand alignment.
- Used after add/sub and mul/div to normalize mantissas, or to apply an explicit left shift.
- Applies one power-of-two stage per clock, largest stage first, behind a valid/ready handshake on both sides.
- Reports the applied shift amount, a zero flag and an overflow flag for nonzero bits shifted out of the MSB end.

Parameters:
- n, 8, data bits; must satisfy 2**s - 1 < n.
- s, 3, shift-select bits; number of stages; maximum shift is 2**s - 1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept an operand.
- in  input  n  data to shift.
- sel  input  s  explicit shift amount; ignored when norm=1.
- norm  input  1  1 = normalize: shift left until MSB=1 or the maximum shift is reached.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  n  shifted data, zero-filled from the LSB.
- shamt  output  s  shift amount actually applied.
- overflow  output  1  OR of all bits shifted out past bit n-1.
- zero  output  1  out == 0.

Behaviour:
- FSM states: IDLE, SHIFT, DONE.
- Internal registers: data[n-1:0], amt[s-1:0], ovf, mode, sel_q, stage counter k (0..s-1).
- Reset: state=IDLE, in_ready=1, out_valid=0, out=0, shamt=0, overflow=0, zero=0, k=s-1.
- Reset has priority over every other event. Reset mid-SHIFT or in DONE abandons the transaction; no result is emitted.
- in_ready = (state==IDLE). out_valid = (state==DONE). No overlap between transactions.
- IDLE, when in_valid=1: on that edge latch data=in, sel_q=sel, mode=norm; clear amt and ovf; set k=s-1; go to SHIFT.
- SHIFT, one edge per stage i=k, descending from s-1 to 0. The stage shifts by 2**i when:
  - mode=0: sel_q[i]=1;
  - mode=1: data[n-1 -: 2**i] == 0.
- When a stage shifts:
  - data <<= 2**i, zero-filled;
  - amt[i] = 1;
  - ovf |= |data[n-1 -: 2**i].
- After stage 0 go to DONE. The DONE outputs out/shamt/overflow/zero reflect the final data/amt/ovf.
- Latency: input handshake at edge T gives out_valid=1 from edge T+s. Example: n=8, s=3 gives T+3.
- DONE: outputs hold stable while out_ready=0, for unbounded backpressure. On out_valid && out_ready go to IDLE, so in_ready=1 on the following cycle.
- Norm mode:
  - overflow is always 0.
  - A nonzero input yields out[n-1]=1 and shamt = leading-zero count, capped at 2**s-1.
  - A zero input yields out=0, shamt=2**s-1, zero=1.
- Explicit mode: sel=0 passes the data through in s cycles with shamt=0. zero may be 1 when all set bits were shifted out, in which case overflow=1.
- in and sel changes while not in IDLE are ignored.

Test Plan:
- Explicit shift: in=8'h13, sel=3, norm=0, accepted at edge T -> out_valid at T+3, out=8'h98, shamt=3, overflow=0, zero=0.
- Overflow: in=8'hA1, sel=2, norm=0 -> out=8'h84, shamt=2, overflow=1. Second case: in=8'h3F, sel=2 -> out=8'hFC, overflow=0.
- Normalize: in=8'h05, norm=1 -> out=8'hA0, shamt=5, overflow=0. Second case: in=8'h80 -> out=8'h80, shamt=0.
- Normalize zero: in=8'h00, norm=1 -> out=8'h00, shamt=7, zero=1, overflow=0.
- Backpressure: hold out_ready=0 for 4 cycles after out_valid -> out/shamt/flags constant, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> next cycle out_valid=0, in_ready=1.
- Reset mid-op: assert reset one cycle after acceptance (in SHIFT) -> next cycle in_ready=1, out_valid=0, out=0. A following operand (in=8'h01, norm=1) yields out=8'h80, shamt=7 with normal latency.
